rb_commit_unit: RTL and testbench

//  In-order retirement stage for the reorder buffer (RB). Allocates RB entries at issue.

---
 rtl/rb_commit_unit_pkg.sv | 21 ++
 rtl/rb_commit_unit_if.sv | 38 +++
 rtl/rb_commit_unit_entry_table.sv | 71 +++++++
 rtl/rb_commit_unit.sv | 122 ++++++++++++
 tb/tb_rb_commit_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rb_commit_unit_pkg.sv
// Shared sizing, index helpers and FSM encoding for the reorder-buffer commit unit.
package rb_commit_unit_pkg;
    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 3;
    localparam int REG_INDEX = 5;

    typedef logic [RB_INDEX-1:0] rb_idx_t;

    // All-ones index means "no entry"; the ring therefore only spans 0..RB_SIZE-2.
    localparam rb_idx_t RB_NULL = '1;

    typedef enum logic {
        ST_COMMIT     = 1'b0,
        ST_STORE_WAIT = 1'b1
    } commit_state_e;

    function automatic rb_idx_t rb_next(input rb_idx_t idx);
        return (idx == rb_idx_t'(RB_SIZE - 2)) ? '0 : idx + rb_idx_t'(1);
    endfunction
endpackage

// File: rtl/rb_commit_unit_if.sv
// Issue, CDB, register-file and store-port signals of the commit unit.
interface rb_commit_unit_if;
    import rb_commit_unit_pkg::*;

    logic [WORD_SIZE*RB_SIZE-1:0] cdb_data_data;
    logic [RB_SIZE-1:0]           cdb_data_valid;
    logic [WORD_SIZE*RB_SIZE-1:0] cdb_data_addr;
    logic                         alloc_req;
    logic                         alloc_is_store;
    logic [REG_INDEX-1:0]         alloc_dest;
    logic                         alloc_grant;
    rb_idx_t                      alloc_index;
    logic                         rb_full;
    logic                         reg_we;
    logic [REG_INDEX-1:0]         reg_waddr;
    logic [WORD_SIZE-1:0]         reg_wdata;
    logic                         mem_we;
    logic [WORD_SIZE-1:0]         mem_addr;
    logic [WORD_SIZE-1:0]         mem_wdata;
    logic                         mem_ack;
    logic [RB_SIZE-1:0]           commit_free;

    modport master (
        output cdb_data_data, cdb_data_valid, cdb_data_addr,
        output alloc_req, alloc_is_store, alloc_dest, mem_ack,
        input  alloc_grant, alloc_index, rb_full,
        input  reg_we, reg_waddr, reg_wdata,
        input  mem_we, mem_addr, mem_wdata, commit_free
    );

    modport slave (
        input  cdb_data_data, cdb_data_valid, cdb_data_addr,
        input  alloc_req, alloc_is_store, alloc_dest, mem_ack,
        output alloc_grant, alloc_index, rb_full,
        output reg_we, reg_waddr, reg_wdata,
        output mem_we, mem_addr, mem_wdata, commit_free
    );
endinterface

// File: rtl/rb_commit_unit_entry_table.sv
// Per-entry busy/dest/is_store bookkeeping with the head/tail ring pointers and occupancy count.
module rb_commit_unit_entry_table
    import rb_commit_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_alloc_req,
    input  logic                 i_alloc_is_store,
    input  logic [REG_INDEX-1:0] i_alloc_dest,
    input  logic                 i_retire,
    output logic                 o_alloc_ok,
    output rb_idx_t              o_tail,
    output rb_idx_t              o_head,
    output logic                 o_full,
    output logic                 o_head_busy,
    output logic                 o_head_is_store,
    output logic [REG_INDEX-1:0] o_head_dest
);
    localparam logic [RB_INDEX:0] CNT_FULL = (RB_INDEX + 1)'(RB_SIZE - 1);

    logic [RB_SIZE-1:0]   r_busy;
    logic [RB_SIZE-1:0]   r_is_store;
    logic [REG_INDEX-1:0] r_dest [RB_SIZE];
    rb_idx_t              r_head;
    rb_idx_t              r_tail;
    logic [RB_INDEX:0]    r_count;

    logic w_empty;
    logic w_retire_ok;

    assign w_empty     = (r_count == '0);
    // Full is judged on the pre-edge count, so a same-cycle retirement cannot open a slot.
    assign o_full      = (r_count == CNT_FULL);
    assign o_alloc_ok  = i_alloc_req && !o_full;
    assign w_retire_ok = i_retire && !w_empty;

    assign o_tail          = r_tail;
    assign o_head          = r_head;
    assign o_head_busy     = r_busy[r_head] && !w_empty;
    assign o_head_is_store = r_is_store[r_head];
    assign o_head_dest     = r_dest[r_head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_is_store <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int k = 0; k < RB_SIZE; k++) begin
                r_dest[k] <= '0;
            end
        end else begin
            if (o_alloc_ok) begin
                r_busy[r_tail]     <= 1'b1;
                r_is_store[r_tail] <= i_alloc_is_store;
                r_dest[r_tail]     <= i_alloc_dest;
                r_tail             <= rb_next(r_tail);
            end
            if (w_retire_ok) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= rb_next(r_head);
            end
            case ({o_alloc_ok, w_retire_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/rb_commit_unit.sv
// In-order retirement stage: allocates RB entries at issue and retires the head to the
// register file or, for stores, through a held request/ack store port.
module rb_commit_unit
    import rb_commit_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    rb_commit_unit_if.slave rb_bus
);
    commit_state_e        r_state;
    logic                 r_alloc_grant;
    rb_idx_t              r_alloc_index;
    logic                 r_reg_we;
    logic [REG_INDEX-1:0] r_reg_waddr;
    logic [WORD_SIZE-1:0] r_reg_wdata;
    logic                 r_mem_we;
    logic [WORD_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic [RB_SIZE-1:0]   r_commit_free;

    logic                 w_alloc_ok;
    logic                 w_full;
    logic                 w_head_busy;
    logic                 w_head_is_store;
    logic                 w_head_ready;
    logic                 w_retire;
    rb_idx_t              w_head;
    rb_idx_t              w_tail;
    logic [REG_INDEX-1:0] w_head_dest;
    logic [RB_SIZE-1:0]   w_head_onehot;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0] w_data_arr;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0] w_addr_arr;

    assign w_data_arr   = rb_bus.cdb_data_data;
    assign w_addr_arr   = rb_bus.cdb_data_addr;
    assign w_head_ready = w_head_busy && rb_bus.cdb_data_valid[w_head];
    // Stores leave the table only when memory acknowledges them.
    assign w_retire     = (r_state == ST_COMMIT) ? (w_head_ready && !w_head_is_store)
                                                 : rb_bus.mem_ack;

    always_comb begin
        w_head_onehot         = '0;
        w_head_onehot[w_head] = 1'b1;
    end

    rb_commit_unit_entry_table u_entry_table (
        .clk              (clk),
        .rst              (rst),
        .i_alloc_req      (rb_bus.alloc_req),
        .i_alloc_is_store (rb_bus.alloc_is_store),
        .i_alloc_dest     (rb_bus.alloc_dest),
        .i_retire         (w_retire),
        .o_alloc_ok       (w_alloc_ok),
        .o_tail           (w_tail),
        .o_head           (w_head),
        .o_full           (w_full),
        .o_head_busy      (w_head_busy),
        .o_head_is_store  (w_head_is_store),
        .o_head_dest      (w_head_dest)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc_grant <= 1'b0;
            r_alloc_index <= RB_NULL;
        end else begin
            r_alloc_grant <= w_alloc_ok;
            r_alloc_index <= w_alloc_ok ? w_tail : RB_NULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_COMMIT;
            r_reg_we      <= 1'b0;
            r_reg_waddr   <= '0;
            r_reg_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_commit_free <= '0;
        end else begin
            r_reg_we      <= 1'b0;
            r_commit_free <= '0;
            case (r_state)
                ST_COMMIT: begin
                    if (w_head_ready) begin
                        if (w_head_is_store) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_addr_arr[w_head];
                            r_mem_wdata <= w_data_arr[w_head];
                            r_state     <= ST_STORE_WAIT;
                        end else begin
                            r_reg_we      <= 1'b1;
                            r_reg_waddr   <= w_head_dest;
                            r_reg_wdata   <= w_data_arr[w_head];
                            r_commit_free <= w_head_onehot;
                        end
                    end
                end
                ST_STORE_WAIT: begin
                    if (rb_bus.mem_ack) begin
                        r_mem_we      <= 1'b0;
                        r_commit_free <= w_head_onehot;
                        r_state       <= ST_COMMIT;
                    end
                end
            endcase
        end
    end

    assign rb_bus.alloc_grant = r_alloc_grant;
    assign rb_bus.alloc_index = r_alloc_index;
    assign rb_bus.rb_full     = w_full;
    assign rb_bus.reg_we      = r_reg_we;
    assign rb_bus.reg_waddr   = r_reg_waddr;
    assign rb_bus.reg_wdata   = r_reg_wdata;
    assign rb_bus.mem_we      = r_mem_we;
    assign rb_bus.mem_addr    = r_mem_addr;
    assign rb_bus.mem_wdata   = r_mem_wdata;
    assign rb_bus.commit_free = r_commit_free;
endmodule

// File: tb/tb_rb_commit_unit.sv
// Scoreboard bench for rb_commit_unit: expected retirements queued in allocation order.
module tb_rb_commit_unit;
    import rb_commit_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rb_commit_unit_if bus ();

    rb_commit_unit dut (
        .clk    (clk),
        .rst    (rst),
        .rb_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 is_store;
        logic [REG_INDEX-1:0] dest;
        logic [WORD_SIZE-1:0] data;
        logic [WORD_SIZE-1:0] addr;
        logic [RB_SIZE-1:0]   free;
    } exp_t;

    exp_t exp_q[$];

    int n_checks      = 0;
    int n_fail        = 0;
    int n_retired     = 0;
    int m_count       = 0;
    int mem_we_cycles = 0;
    int base;
    rb_idx_t m_tail   = '0;
    bit auto_valid    = 1'b0;

    logic [RB_SIZE-1:0][WORD_SIZE-1:0] cdb_word;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0] cdb_addr;
    logic [WORD_SIZE-1:0] ent_data [RB_SIZE];
    logic [WORD_SIZE-1:0] ent_addr [RB_SIZE];

    logic                 p_store;
    logic [REG_INDEX-1:0] p_dest;
    logic [WORD_SIZE-1:0] p_data;
    logic [WORD_SIZE-1:0] p_addr;

    assign bus.cdb_data_data = cdb_word;
    assign bus.cdb_data_addr = cdb_addr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_alloc_grant"}, 32'(bus.alloc_grant), 32'd0);
        check_eq({tag, "_alloc_index"}, 32'(bus.alloc_index), 32'(RB_NULL));
        check_eq({tag, "_rb_full"},     32'(bus.rb_full),     32'd0);
        check_eq({tag, "_reg_we"},      32'(bus.reg_we),      32'd0);
        check_eq({tag, "_reg_waddr"},   32'(bus.reg_waddr),   32'd0);
        check_eq({tag, "_reg_wdata"},   bus.reg_wdata,        32'd0);
        check_eq({tag, "_mem_we"},      32'(bus.mem_we),      32'd0);
        check_eq({tag, "_mem_addr"},    bus.mem_addr,         32'd0);
        check_eq({tag, "_mem_wdata"},   bus.mem_wdata,        32'd0);
        check_eq({tag, "_commit_free"}, 32'(bus.commit_free), 32'd0);
    endtask

    task automatic set_valid(input rb_idx_t idx);
        cdb_word[idx]           = ent_data[idx];
        cdb_addr[idx]           = ent_addr[idx];
        bus.cdb_data_valid[idx] = 1'b1;
    endtask

    task automatic alloc(input logic st, input logic [REG_INDEX-1:0] d,
                         input logic [WORD_SIZE-1:0] data, input logic [WORD_SIZE-1:0] addr);
        bus.alloc_req      = 1'b1;
        bus.alloc_is_store = st;
        bus.alloc_dest     = d;
        p_store = st;
        p_dest  = d;
        p_data  = data;
        p_addr  = addr;
    endtask

    task automatic monitor();
        exp_t e;
        if (bus.mem_we) begin
            mem_we_cycles++;
            if (exp_q.size() == 0 || !exp_q[0].is_store) begin
                check_eq("mem_we_unexpected", 32'(bus.mem_we), 32'd0);
            end else begin
                check_eq("mem_addr",  bus.mem_addr,  exp_q[0].addr);
                check_eq("mem_wdata", bus.mem_wdata, exp_q[0].data);
            end
        end
        if (bus.reg_we || bus.commit_free != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("retire_unexpected", 32'({bus.reg_we, bus.commit_free}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                n_retired++;
                m_count--;
                check_eq("retire_kind", 32'(bus.reg_we),      32'(!e.is_store));
                check_eq("commit_free", 32'(bus.commit_free), 32'(e.free));
                if (e.is_store) begin
                    check_eq("mem_we_drop", 32'(bus.mem_we), 32'd0);
                end else begin
                    check_eq("reg_waddr", 32'(bus.reg_waddr), 32'(e.dest));
                    check_eq("reg_wdata", bus.reg_wdata,      e.data);
                end
                bus.cdb_data_valid &= ~e.free;
            end
        end
    endtask

    task automatic tick();
        logic req;
        logic exp_grant;
        exp_t e;
        logic [RB_SIZE-1:0] oh;
        req       = bus.alloc_req;
        exp_grant = req && (m_count < RB_SIZE - 1);
        @(posedge clk);
        #1;
        check_eq("alloc_grant", 32'(bus.alloc_grant), 32'(exp_grant));
        if (exp_grant) begin
            check_eq("alloc_index", 32'(bus.alloc_index), 32'(m_tail));
            ent_data[m_tail] = p_data;
            ent_addr[m_tail] = p_addr;
            oh         = '0;
            oh[m_tail] = 1'b1;
            e.is_store = p_store;
            e.dest     = p_dest;
            e.data     = p_data;
            e.addr     = p_addr;
            e.free     = oh;
            exp_q.push_back(e);
            if (auto_valid) set_valid(m_tail);
            m_tail = (m_tail == rb_idx_t'(RB_SIZE - 2)) ? '0 : m_tail + 3'd1;
            m_count++;
        end else begin
            check_eq("alloc_index", 32'(bus.alloc_index), 32'(RB_NULL));
        end
        bus.alloc_req = 1'b0;
        monitor();
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.alloc_req      = 1'b0;
        bus.alloc_is_store = 1'b0;
        bus.alloc_dest     = '0;
        bus.mem_ack        = 1'b0;
        bus.cdb_data_valid = '0;
        cdb_word           = '0;
        cdb_addr           = '0;
        auto_valid         = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_tail  = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Three allocations, then head valid -> one register write.
        alloc(1'b0, 5'd1, 32'h11, 32'h0); tick();
        alloc(1'b0, 5'd2, 32'h22, 32'h0); tick();
        alloc(1'b0, 5'd3, 32'h33, 32'h0); tick();
        base = n_retired;
        set_valid(3'd0);
        tick();
        check_eq("t1_retired", 32'(n_retired - base), 32'd1);
        tick();
        check_eq("t1_reg_we_pulse", 32'(bus.reg_we), 32'd0);
        check_eq("t1_free_pulse",   32'(bus.commit_free), 32'd0);

        // Younger entry ready first must wait for the head.
        do_reset();
        alloc(1'b0, 5'd4, 32'hA4, 32'h0); tick();
        alloc(1'b0, 5'd5, 32'hA5, 32'h0); tick();
        base = n_retired;
        set_valid(3'd1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("t2_no_early_retire", 32'(n_retired - base), 32'd0);
        set_valid(3'd0);
        tick();
        check_eq("t2_first_retire", 32'(n_retired - base), 32'd1);
        tick();
        check_eq("t2_second_retire", 32'(n_retired - base), 32'd2);

        // Store with delayed ack; stray ack while idle must be ignored.
        do_reset();
        bus.mem_ack = 1'b1;
        tick();
        check_eq("t3_idle_ack_free", 32'(bus.commit_free), 32'd0);
        bus.mem_ack = 1'b0;
        alloc(1'b1, 5'd0, 32'hBEEF, 32'h100); tick();
        alloc(1'b0, 5'd7, 32'h77,   32'h0);   tick();
        base = n_retired;
        set_valid(3'd0);
        set_valid(3'd1);
        mem_we_cycles = 0;
        tick();
        check_eq("t3_mem_we_rise", 32'(bus.mem_we), 32'd1);
        tick();
        tick();
        bus.mem_ack = 1'b1;
        tick();
        check_eq("t3_mem_we_cycles", 32'(mem_we_cycles), 32'd3);
        check_eq("t3_store_retired", 32'(n_retired - base), 32'd1);
        bus.mem_ack = 1'b0;
        tick();
        check_eq("t3_after_store", 32'(n_retired - base), 32'd2);

        // Fill to capacity; retire-while-full still rejects the allocation.
        do_reset();
        for (int i = 0; i < RB_SIZE - 1; i++) begin
            alloc(1'b0, 5'(i + 8), 32'h500 + 32'(i), 32'h0);
            tick();
        end
        check_eq("t4_rb_full", 32'(bus.rb_full), 32'd1);
        alloc(1'b0, 5'd20, 32'h600, 32'h0);
        tick();
        base = n_retired;
        set_valid(3'd0);
        alloc(1'b0, 5'd21, 32'h601, 32'h0);
        tick();
        check_eq("t4_retire_when_full", 32'(n_retired - base), 32'd1);
        check_eq("t4_not_full", 32'(bus.rb_full), 32'd0);
        alloc(1'b0, 5'd22, 32'h602, 32'h0);
        tick();
        check_eq("t4_wrap_index", 32'(bus.alloc_index), 32'd0);

        // Streaming allocate/retire across several ring wraps.
        do_reset();
        auto_valid = 1'b1;
        base = n_retired;
        for (int i = 0; i < 20; i++) begin
            alloc(1'b0, 5'((i % 31) + 1), 32'h1000 + 32'(i), 32'h0);
            tick();
            check_eq("t5_index_not_null", 32'(bus.alloc_index == RB_NULL), 32'd0);
        end
        check_eq("t5_throughput", 32'(n_retired - base), 32'd19);
        auto_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
        check_eq("t5_drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("t5_total", 32'(n_retired - base), 32'd20);

        // Reset asserted while waiting for a store ack.
        do_reset();
        alloc(1'b1, 5'd0, 32'hCAFE, 32'h200); tick();
        set_valid(3'd0);
        tick();
        check_eq("t6_mem_we_set", 32'(bus.mem_we), 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6");
        do_reset();
        tick();
        check_eq("t6_no_retire_after_reset", 32'(bus.commit_free), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
